// File: rtl/shift_seq_ctrl_if.sv
// Request/status bundle between a host and the shift sequencer.
// The host drives the request fields; the sequencer reports status.
interface shift_seq_ctrl_if #(
    parameter int W     = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [1:0]       op;
    logic             seed_sel;
    logic [CNT_W-1:0] count;
    logic             match_en;
    logic [W-1:0]     target;
    logic             abort;
    logic             busy;
    logic             done;
    logic             hit;
    logic [CNT_W-1:0] steps;

    modport master (
        output start, op, seed_sel, count, match_en, target, abort,
        input  busy, done, hit, steps
    );

    modport slave (
        input  start, op, seed_sel, count, match_en, target, abort,
        output busy, done, hit, steps
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the seed-mux / feedback-mux / shifter / register datapath:
// seeds the register, applies up to count steps, stops early on target match.
module shift_seq_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           clear,
    shift_seq_ctrl_if.slave req,
    input  logic [W-1:0]   reg_q,
    output logic           sel1,
    output logic           sel2,
    output logic [1:0]     func,
    output logic           load,
    output logic           dp_clear
);

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       op_l;
    logic             seed_l;
    logic [CNT_W-1:0] cnt_l;
    logic             men_l;
    logic [W-1:0]     tgt_l;
    logic [CNT_W-1:0] steps_q;
    logic [CNT_W-1:0] steps_nx;
    logic             hit_q;
    logic             hit_nx;
    logic             matched;

    assign matched = men_l && (reg_q == tgt_l);

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            op_l    <= '0;
            seed_l  <= 1'b0;
            cnt_l   <= '0;
            men_l   <= 1'b0;
            tgt_l   <= '0;
            steps_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            steps_q <= steps_nx;
            hit_q   <= hit_nx;
            if (state == IDLE && req.start) begin
                op_l   <= req.op;
                seed_l <= req.seed_sel;
                cnt_l  <= req.count;
                men_l  <= req.match_en;
                tgt_l  <= req.target;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        steps_nx  = steps_q;
        hit_nx    = hit_q;
        sel1      = seed_l;
        sel2      = 1'b0;
        func      = 2'b00;
        load      = 1'b0;
        dp_clear  = 1'b0;
        req.busy  = 1'b0;
        req.done  = 1'b0;
        req.hit   = hit_q;
        req.steps = steps_q;

        unique case (state)
            IDLE: begin
                if (req.start) begin
                    steps_nx = '0;
                    hit_nx   = 1'b0;
                    state_nx = SEED;
                end
            end
            SEED: begin
                req.busy = 1'b1;
                if (req.abort) begin
                    dp_clear = 1'b1;
                    hit_nx   = 1'b0;
                    state_nx = IDLE;
                end else begin
                    load     = 1'b1;
                    state_nx = (cnt_l == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                req.busy = 1'b1;
                if (req.abort) begin
                    dp_clear = 1'b1;
                    hit_nx   = 1'b0;
                    state_nx = IDLE;
                end else if (matched) begin
                    // the matching value is kept, so no shift this cycle
                    hit_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    sel2     = 1'b1;
                    func     = op_l;
                    load     = 1'b1;
                    steps_nx = steps_q + 1'b1;
                    if (steps_nx == cnt_l) state_nx = DONE;
                end
            end
            DONE: begin
                req.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // reset dominates everything visible while it is held
        if (clear) begin
            sel1      = 1'b0;
            sel2      = 1'b0;
            func      = 2'b00;
            load      = 1'b0;
            dp_clear  = 1'b1;
            req.busy  = 1'b0;
            req.done  = 1'b0;
            req.hit   = 1'b0;
            req.steps = '0;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a datapath model closes the loop on reg_q,
// and a transaction-level model predicts steps, hit, final value, latency.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       clear;
    logic [7:0] reg_q;
    logic       sel1;
    logic       sel2;
    logic [1:0] func;
    logic       load;
    logic       dp_clear;

    int n_chk = 0;
    int n_err = 0;

    shift_seq_ctrl_if #(.W(8), .CNT_W(4)) bus ();

    shift_seq_ctrl #(.W(8), .CNT_W(4)) dut (
        .clk      (clk),
        .clear    (clear),
        .req      (bus.slave),
        .reg_q    (reg_q),
        .sel1     (sel1),
        .sel2     (sel2),
        .func     (func),
        .load     (load),
        .dp_clear (dp_clear)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] shf(input logic [1:0] f,
                                       input logic [7:0] v);
        int x;
        x = int'(v);
        case (f)
            2'd0:    return v;
            2'd1:    return 8'((x * 2) % 256);
            2'd2:    return 8'(x / 2);
            default: return 8'(((x * 2) % 256) + (x / 128));
        endcase
    endfunction

    // datapath the controller steers
    always @(posedge clk) begin
        if (dp_clear)
            reg_q <= 8'h00;
        else if (load)
            reg_q <= shf(func, sel2 ? reg_q : (sel1 ? 8'h01 : 8'h80));
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        bus.op       = 2'($urandom);
        bus.seed_sel = 1'($urandom);
        bus.count    = 4'($urandom);
        bus.match_en = 1'($urandom);
        bus.target   = 8'($urandom);
    endtask

    task automatic do_op(input logic [1:0] o, input logic s,
                         input logic [3:0] c, input logic me,
                         input logic [7:0] t);
        logic [7:0] v;
        int st;
        int lat;
        bit h;
        int k;
        v  = s ? 8'h01 : 8'h80;
        st = 0;
        h  = 0;
        while (st < int'(c)) begin
            if (me && v == t) begin
                h = 1;
                break;
            end
            v = shf(o, v);
            st++;
        end
        lat = h ? st + 2 : int'(c) + 1;

        @(negedge clk);
        bus.op = o;
        bus.seed_sel = s;
        bus.count = c;
        bus.match_en = me;
        bus.target = t;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) break;
            chk("busy", bus.busy, 1);
            scramble();
            bus.start = (k + 1 <= lat) ? 1'($urandom) : 1'b0;
        end
        bus.start = 1'b0;
        chk("latency", k, lat);
        chk("done_busy", bus.busy, 0);
        chk("steps", bus.steps, st);
        chk("hit", bus.hit, h);
        chk("final", reg_q, v);
        @(posedge clk);
        #1;
        chk("idle_done", bus.done, 0);
        chk("hold", reg_q, v);
    endtask

    task automatic do_abort(input logic [1:0] o, input logic s,
                            input logic [3:0] c, input int at,
                            input bit use_clear);
        int exp_st;
        exp_st = use_clear ? 0 : ((at >= 2) ? at - 2 : 0);
        @(negedge clk);
        bus.op = o;
        bus.seed_sel = s;
        bus.count = c;
        bus.match_en = 1'b0;
        bus.target = 8'h00;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k < at; k++) begin
            @(posedge clk);
            #1;
        end
        if (use_clear) clear = 1'b1;
        else bus.abort = 1'b1;
        #1;
        chk("abt_dpclr", dp_clear, 1);
        chk("abt_load", load, 0);
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        clear = 1'b0;
        chk("abt_busy", bus.busy, 0);
        chk("abt_done", bus.done, 0);
        chk("abt_steps", bus.steps, exp_st);
        chk("abt_hit", bus.hit, 0);
        chk("abt_reg", reg_q, 0);
        @(posedge clk);
        #1;
        chk("abt_nodone", bus.done, 0);
        chk("abt_idle", bus.busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] o;
        logic       s;
        logic [3:0] c;
        logic       me;
        logic [7:0] t;
        logic [7:0] v;

        clear = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        scramble();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_dpclr", dp_clear, 1);
            chk("rst_outs", {sel1, sel2, func, load}, 0);
            chk("rst_stat", {bus.busy, bus.done, bus.hit, bus.steps}, 0);
            chk("rst_reg", reg_q, 0);
        end
        clear = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_done", bus.done, 0);
        chk("post_rst_dpclr", dp_clear, 0);

        do_op(2'b01, 1'b1, 4'd3, 1'b0, 8'h00);
        do_op(2'b10, 1'b0, 4'd7, 1'b1, 8'h10);
        do_op(2'b11, 1'b0, 4'd8, 1'b0, 8'h00);
        do_op(2'b11, 1'b0, 4'd8, 1'b1, 8'h80);
        do_op(2'b01, 1'b1, 4'd0, 1'b0, 8'h00);
        do_op(2'b11, 1'b1, 4'd15, 1'b0, 8'h00);
        do_op(2'b01, 1'b1, 4'd3, 1'b1, 8'h08);

        do_abort(2'b01, 1'b1, 4'd5, 4, 1'b0);
        do_abort(2'b10, 1'b0, 4'd5, 1, 1'b0);
        do_abort(2'b11, 1'b0, 4'd6, 4, 1'b1);

        for (int n = 0; n < 40; n++) begin
            o  = 2'($urandom);
            s  = 1'($urandom);
            c  = 4'($urandom);
            me = 1'($urandom);
            v  = s ? 8'h01 : 8'h80;
            for (int j = $urandom_range(0, 9); j > 0; j--) v = shf(o, v);
            t  = $urandom_range(0, 1) ? v : 8'($urandom);
            do_op(o, s, c, me, t);
        end

        for (int n = 0; n < 12; n++) begin
            c = 4'($urandom_range(1, 15));
            do_abort(2'($urandom), 1'($urandom), c,
                     $urandom_range(1, int'(c) + 1), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
